multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore control FSM that sequences the shared-memory, single-ALU multicycle RISC-V datapath.
//  Supports lw, sw, R-type ALU, I-type ALU, beq and jal; decodes op/funct3/funct7_5 from the IR.
//  Issues datapath mux selects, write enables and the memory request handshake.
//  Replaces the combinational single-cycle control path; one instruction takes 3-5 states plus memory waits.
// PARAMETERS
//  MEM_WAIT    1   1: FETCH/MEMREAD/MEMWRITE hold until mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk          in   1  clock; all state updates on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  op           in   7  Instr[6:0] from the IR
//  funct3       in   3  Instr[14:12]
//  funct7_5     in   1  Instr[30]
//  Zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_req      out  1  memory access requested
//  AdrSrc       out  1  0=PC, 1=ALUOut as memory address
//  IRWrite      out  1  load IR and OldPC
//  PCWrite      out  1  load PC from Result
//  MemWrite     out  1  store strobe
//  RegWrite     out  1  register-file write
//  ALUSrcA      out  2  00=PC, 01=OldPC, 10=rs1 (A reg)
//  ALUSrcB      out  2  00=rs2 (WriteData reg), 01=ImmExt, 10=constant 4
//  ResultSrc    out  2  00=ALUOut, 01=Data reg, 10=ALUResult
//  ImmSrc       out  2  00=I, 01=S, 10=B, 11=J (combinational from op)
//  ALUControl   out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal_op   out  1  one-cycle pulse: unsupported opcode decoded
//  instr_done   out  1  one-cycle pulse on the final state of each instruction
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL.
//  Reset: state=FETCH asynchronously; while rst_n=0, mem_req, IRWrite, PCWrite, MemWrite, RegWrite,
//   illegal_op and instr_done are forced 0; the select outputs show their FETCH values.
//  FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10.
//   IRWrite=PCWrite=mem_ready. Holds until mem_ready, then goes to DECODE.
//  DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target). Next state by op:
//   0000011->MEMADR, 0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ,
//   1101111->JAL, any other->ILLEGAL.
//  MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD if op[5]=0, else MEMWRITE.
//  MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Holds until mem_ready, then goes to MEMWB.
//  MEMWB: ResultSrc=01, RegWrite=1, instr_done=1, then FETCH.
//  MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=mem_ready. Holds; on mem_ready instr_done=1, then FETCH.
//  EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct.
//   Both then go to ALUWB.
//  ALUWB: ResultSrc=00, RegWrite=1, instr_done=1, then FETCH.
//  BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero, instr_done=1, then FETCH.
//  JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (rd<=OldPC+4).
//  ILLEGAL: no write enables; illegal_op=1, instr_done=1, then FETCH (PC already advanced).
//  ALUOp=funct decode by funct3:
//   000 -> sub if op[5]&funct7_5, else add; 010 -> slt; 110 -> or; 111 -> and; other -> add.
//  Unlisted outputs are 0 in each state. MemWrite/RegWrite are never high in the same cycle.
//  With mem_ready=1 every cycle: lw=5, sw=4, R/I=4, beq=3, jal=4 cycles.
//  Reset mid-wait: the access is abandoned and mem_req drops immediately.
// TESTING
//  lw x5,8(x1), mem_ready=1 -> states F,D,MA,MR,MWB; RegWrite only in cycle 5; instr_done cycle 5.
//  sw with mem_ready low 3 cycles in MEMWRITE -> mem_req held 4 cycles; MemWrite only on ready cycle.
//  sub (op=0110011, f3=000, f7_5=1) -> ALUControl=001 in EXECR; add with f7_5=0 -> 000.
//  beq: Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
//  jal -> PCWrite in JAL, then RegWrite in ALUWB with ResultSrc=00; op=0000000 -> illegal_op pulse.
//  rst_n low during FETCH wait -> mem_req=0 at once; after release first cycle is FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave):
// instruction fields and status in, mux selects, write enables and memory handshake out.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero;
    logic       mem_ready;

    logic       mem_req;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal_op;
    logic       instr_done;

    modport master (
        input  op, funct3, funct7_5, Zero, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal_op, instr_done
    );

    modport slave (
        output op, funct3, funct7_5, Zero, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal_op, instr_done
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared-memory, single-ALU multicycle RISC-V datapath
// (lw, sw, R-type, I-type, beq, jal); one instruction takes 3-5 states plus memory waits.
module multicycle_controller #(
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);

    localparam int unsigned OP_W  = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

    localparam logic [SEL_W-1:0] SRCA_PC     = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_RS2    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b10;
    localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA    = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES  = 2'b10;
    localparam logic [SEL_W-1:0] IMM_I       = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S       = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B       = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J       = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_ILLEGAL
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              ready;
    logic              mem_req_c;
    logic              adr_src_c;
    logic              ir_write_c;
    logic              pc_write_c;
    logic              mem_write_c;
    logic              reg_write_c;
    logic              illegal_c;
    logic              done_c;
    logic [SEL_W-1:0]  src_a_c;
    logic [SEL_W-1:0]  src_b_c;
    logic [SEL_W-1:0]  result_src_c;
    logic [SEL_W-1:0]  imm_src_c;
    logic [ALU_W-1:0]  alu_ctrl_c;

    // With MEM_WAIT cleared the memory is assumed to complete every access in one cycle.
    assign ready = !MEM_WAIT || bus.mem_ready;

    // funct3/funct7 ALU decode; subtraction only for R-type (op[5]=1) with funct7_5 set.
    function automatic logic [ALU_W-1:0] alu_funct(input logic            op5,
                                                   input logic [F3_W-1:0] f3,
                                                   input logic            f7_5);
        logic [ALU_W-1:0] ctrl;
        case (f3)
            3'b000:  ctrl = (op5 && f7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  ctrl = ALU_SLT;
            3'b110:  ctrl = ALU_OR;
            3'b111:  ctrl = ALU_AND;
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_nxt    = state;
        mem_req_c    = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        illegal_c    = 1'b0;
        done_c       = 1'b0;
        src_a_c      = SRCA_PC;
        src_b_c      = SRCB_RS2;
        result_src_c = RES_ALUOUT;
        alu_ctrl_c   = ALU_ADD;

        case (state)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                src_a_c      = SRCA_PC;
                src_b_c      = SRCB_FOUR;
                result_src_c = RES_ALURES;
                ir_write_c   = ready;
                pc_write_c   = ready;
                if (ready) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_IMM;
                case (bus.op)
                    OP_LOAD,
                    OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE: state_nxt = S_EXECR;
                    OP_ITYPE: state_nxt = S_EXECI;
                    OP_BEQ:   state_nxt = S_BEQ;
                    OP_JAL:   state_nxt = S_JAL;
                    default:  state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                src_a_c   = SRCA_RS1;
                src_b_c   = SRCB_IMM;
                state_nxt = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c    = 1'b1;
                adr_src_c    = 1'b1;
                result_src_c = RES_ALUOUT;
                if (ready) begin
                    state_nxt = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                done_c       = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                adr_src_c   = 1'b1;
                mem_write_c = ready;
                done_c      = ready;
                if (ready) begin
                    state_nxt = S_FETCH;
                end
            end
            S_EXECR: begin
                src_a_c    = SRCA_RS1;
                src_b_c    = SRCB_RS2;
                alu_ctrl_c = alu_funct(bus.op[5], bus.funct3, bus.funct7_5);
                state_nxt  = S_ALUWB;
            end
            S_EXECI: begin
                src_a_c    = SRCA_RS1;
                src_b_c    = SRCB_IMM;
                alu_ctrl_c = alu_funct(bus.op[5], bus.funct3, bus.funct7_5);
                state_nxt  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_c = RES_ALUOUT;
                reg_write_c  = 1'b1;
                done_c       = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_BEQ: begin
                src_a_c      = SRCA_RS1;
                src_b_c      = SRCB_RS2;
                alu_ctrl_c   = ALU_SUB;
                result_src_c = RES_ALUOUT;
                pc_write_c   = bus.Zero;
                done_c       = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_JAL: begin
                // PC <= branch target computed in DECODE; rd gets OldPC+4 in ALUWB.
                src_a_c      = SRCA_OLDPC;
                src_b_c      = SRCB_FOUR;
                alu_ctrl_c   = ALU_ADD;
                result_src_c = RES_ALUOUT;
                pc_write_c   = 1'b1;
                state_nxt    = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
                done_c    = 1'b1;
                state_nxt = S_FETCH;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        imm_src_c = IMM_I;
        case (bus.op)
            OP_STORE: imm_src_c = IMM_S;
            OP_BEQ:   imm_src_c = IMM_B;
            OP_JAL:   imm_src_c = IMM_J;
            default:  imm_src_c = IMM_I;
        endcase
    end

    // Strobes are gated by rst_n so a pending access is dropped the moment reset asserts.
    assign bus.mem_req    = mem_req_c   & rst_n;
    assign bus.IRWrite    = ir_write_c  & rst_n;
    assign bus.PCWrite    = pc_write_c  & rst_n;
    assign bus.MemWrite   = mem_write_c & rst_n;
    assign bus.RegWrite   = reg_write_c & rst_n;
    assign bus.illegal_op = illegal_c   & rst_n;
    assign bus.instr_done = done_c      & rst_n;

    assign bus.AdrSrc     = adr_src_c;
    assign bus.ALUSrcA    = src_a_c;
    assign bus.ALUSrcB    = src_b_c;
    assign bus.ResultSrc  = result_src_c;
    assign bus.ALUControl = alu_ctrl_c;
    assign bus.ImmSrc     = imm_src_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and random instruction streams
// compared cycle by cycle against a per-instruction step plan derived from the ISA behaviour.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_WAIT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] result_src;
        logic [2:0] alu_ctrl;
        logic       illegal;
        logic       done;
    } outs_t;

    typedef enum int {
        K_FETCH, K_DECODE, K_MEMADR, K_READ, K_MEMWB, K_WRITE,
        K_EXECR, K_EXECI, K_ALUWB, K_BEQ, K_JAL, K_ILL
    } kind_e;

    int    n_checks;
    int    n_pass;
    int    instr_no;
    kind_e plan [8];
    int    plan_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic outs_t observed();
        outs_t o;
        o.mem_req    = bus.mem_req;
        o.adr_src    = bus.AdrSrc;
        o.ir_write   = bus.IRWrite;
        o.pc_write   = bus.PCWrite;
        o.mem_write  = bus.MemWrite;
        o.reg_write  = bus.RegWrite;
        o.src_a      = bus.ALUSrcA;
        o.src_b      = bus.ALUSrcB;
        o.result_src = bus.ResultSrc;
        o.alu_ctrl   = bus.ALUControl;
        o.illegal    = bus.illegal_op;
        o.done       = bus.instr_done;
        return o;
    endfunction

    // ALU operation an R/I instruction asks for, in ALUControl encoding.
    function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (f3 == 3'b000) return (o == RT && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == SW)  return 2'b01;
        if (o == BEQ) return 2'b10;
        if (o == JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic outs_t reset_outs();
        outs_t e = '0;
        e.src_b      = 2'b10;
        e.result_src = 2'b10;
        return e;
    endfunction

    function automatic outs_t expect_outs(input kind_e k, input logic rdy, input logic z,
                                          input logic [6:0] o, input logic [2:0] f3, input logic f7);
        outs_t e = '0;
        case (k)
            K_FETCH:  begin e.mem_req = 1; e.src_b = 2'b10; e.result_src = 2'b10;
                            e.ir_write = rdy; e.pc_write = rdy; end
            K_DECODE: begin e.src_a = 2'b01; e.src_b = 2'b01; end
            K_MEMADR: begin e.src_a = 2'b10; e.src_b = 2'b01; end
            K_READ:   begin e.mem_req = 1; e.adr_src = 1; end
            K_MEMWB:  begin e.result_src = 2'b01; e.reg_write = 1; e.done = 1; end
            K_WRITE:  begin e.mem_req = 1; e.adr_src = 1; e.mem_write = rdy; e.done = rdy; end
            K_EXECR:  begin e.src_a = 2'b10; e.alu_ctrl = exp_alu(o, f3, f7); end
            K_EXECI:  begin e.src_a = 2'b10; e.src_b = 2'b01; e.alu_ctrl = exp_alu(o, f3, f7); end
            K_ALUWB:  begin e.reg_write = 1; e.done = 1; end
            K_BEQ:    begin e.src_a = 2'b10; e.alu_ctrl = 3'b001; e.pc_write = z; e.done = 1; end
            K_JAL:    begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1; end
            K_ILL:    begin e.illegal = 1; e.done = 1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    task automatic build_plan(input logic [6:0] o);
        plan[0] = K_FETCH;
        plan[1] = K_DECODE;
        if (o == LW) begin
            plan[2] = K_MEMADR; plan[3] = K_READ; plan[4] = K_MEMWB; plan_len = 5;
        end else if (o == SW) begin
            plan[2] = K_MEMADR; plan[3] = K_WRITE; plan_len = 4;
        end else if (o == RT) begin
            plan[2] = K_EXECR; plan[3] = K_ALUWB; plan_len = 4;
        end else if (o == IT) begin
            plan[2] = K_EXECI; plan[3] = K_ALUWB; plan_len = 4;
        end else if (o == BEQ) begin
            plan[2] = K_BEQ; plan_len = 3;
        end else if (o == JAL) begin
            plan[2] = K_JAL; plan[3] = K_ALUWB; plan_len = 4;
        end else begin
            plan[2] = K_ILL; plan_len = 3;
        end
    endtask

    // waits<0: random stall counts; waits>=0: fetch ready at once, memory steps stall 'waits' cycles.
    // abort_at: step index whose first (stalled) cycle is cut short by reset.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zero_mode, input int waits, input int abort_at);
        build_plan(o);
        instr_no++;
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
        for (int k = 0; k < plan_len; k++) begin
            kind_e kd;
            bit    wt;
            int    low;
            kd = plan[k];
            wt = (kd == K_FETCH) || (kd == K_READ) || (kd == K_WRITE);
            if (!wt)                 low = 0;
            else if (k == abort_at)  low = 1;
            else if (waits < 0)      low = $urandom_range(0, 3);
            else                     low = (kd == K_FETCH) ? 0 : waits;
            forever begin
                @(negedge clk);
                bus.mem_ready = wt ? (low == 0) : 1'($urandom);
                bus.Zero      = (zero_mode < 0) ? 1'($urandom) : 1'(zero_mode);
                #1;
                check($sformatf("i%0d/%s", instr_no, kd.name()), 32'(observed()),
                      32'(expect_outs(kd, bus.mem_ready, bus.Zero, o, f3, f7)));
                check($sformatf("i%0d/%s/imm", instr_no, kd.name()), 32'(bus.ImmSrc), 32'(exp_imm(o)));
                if (wt && k == abort_at) begin
                    rst_n         = 1'b0;
                    bus.mem_ready = 1'b1;
                    #1;
                    check($sformatf("i%0d/abort", instr_no), 32'(observed()), 32'(reset_outs()));
                    @(negedge clk);
                    bus.mem_ready = 1'b0;
                    #1;
                    check($sformatf("i%0d/abort_hold", instr_no), 32'(observed()), 32'(reset_outs()));
                    rst_n = 1'b1;
                    return;
                end
                if (low == 0) break;
                low--;
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        instr_no      = 0;
        rst_n         = 1'b0;
        bus.op        = 7'b0;
        bus.funct3    = 3'b0;
        bus.funct7_5  = 1'b0;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b1;

        // Reset: strobes forced low even with mem_ready high, selects at their FETCH values.
        @(negedge clk);
        #1;
        check("reset", 32'(observed()), 32'(reset_outs()));
        @(negedge clk);
        #1;
        check("reset_hold", 32'(observed()), 32'(reset_outs()));
        bus.mem_ready = 1'b0;
        rst_n         = 1'b1;

        // Directed cases.
        run_instr(LW,  3'b010, 1'b0, -1, 0, -1);
        run_instr(SW,  3'b010, 1'b0, -1, 3, -1);
        run_instr(RT,  3'b000, 1'b1, -1, 0, -1);
        run_instr(RT,  3'b000, 1'b0, -1, 0, -1);
        run_instr(IT,  3'b000, 1'b1, -1, 0, -1);
        run_instr(RT,  3'b110, 1'b0, -1, 0, -1);
        run_instr(IT,  3'b111, 1'b0, -1, 0, -1);
        run_instr(RT,  3'b010, 1'b0, -1, 0, -1);
        run_instr(RT,  3'b001, 1'b0, -1, 0, -1);
        run_instr(BEQ, 3'b000, 1'b0,  1, 0, -1);
        run_instr(BEQ, 3'b000, 1'b0,  0, 0, -1);
        run_instr(JAL, 3'b000, 1'b0, -1, 0, -1);
        run_instr(7'b0000000, 3'b000, 1'b0, -1, 0, -1);
        run_instr(LW,  3'b010, 1'b0, -1, 2, -1);
        run_instr(LW,  3'b010, 1'b0, -1, 0, 0);
        run_instr(LW,  3'b010, 1'b0, -1, 0, 3);
        run_instr(SW,  3'b010, 1'b0, -1, 0, 3);
        run_instr(RT,  3'b000, 1'b1, -1, 0, -1);

        // Random instruction stream with random stalls and occasional reset mid-access.
        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            int         sel;
            int         ab;
            sel = $urandom_range(0, 6);
            case (sel)
                0: o = LW;
                1: o = SW;
                2: o = RT;
                3: o = IT;
                4: o = BEQ;
                5: o = JAL;
                default: o = 7'($urandom);
            endcase
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(o, 3'($urandom), 1'($urandom), -1, -1, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
